// File: rtl/vga_fetch_pkg.sv
// Shared widths and display geometry for the VGA fetch stage, plus the
// frame-buffer address packing used by the fetch FSM.
package vga_fetch_pkg;
    localparam int LOG_MEM     = 36;
    localparam int LOG_HCOUNT  = 10;
    localparam int LOG_VCOUNT  = 10;
    localparam int LOG_ADDR    = 19;
    localparam int VGA_HACTIVE = 640;
    localparam int VGA_VACTIVE = 480;

    // One ZBT word holds two pixels, so the column drops its LSB.
    function automatic logic [LOG_ADDR-1:0] mk_addr(input logic       buf_sel,
                                                    input logic [8:0] line,
                                                    input logic [8:0] pair);
        return {buf_sel, line, pair};
    endfunction
endpackage

// File: rtl/vga_fetch_if.sv
// Memory-arbiter port of the VGA fetch stage: request/address out, grant/data back.
interface vga_fetch_if;
    import vga_fetch_pkg::*;
    logic                mem_req;
    logic [LOG_ADDR-1:0] mem_addr;
    logic                mem_grant;
    logic [LOG_MEM-1:0]  mem_rdata;

    modport master (output mem_req, mem_addr, input mem_grant, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_grant, mem_rdata);
endinterface

// File: rtl/vga_fetch.sv
// Fetches one two-pixel ZBT word per VGA request from the displayed buffer and
// owns front/back buffer selection, which only flips during vertical blank.
module vga_fetch
    import vga_fetch_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int H_ACTIVE    = VGA_HACTIVE,
    parameter int V_ACTIVE    = VGA_VACTIVE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] clocked_hcount,
    input  logic [LOG_VCOUNT-1:0] clocked_vcount,
    input  logic                  frame_flag,
    vga_fetch_if.master           mem,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    output logic                  rd_buf,
    output logic                  overrun,
    output logic                  late
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [LOG_HCOUNT-1:0] H_LIM    = LOG_HCOUNT'(H_ACTIVE);
    localparam logic [LOG_VCOUNT-1:0] V_LIM    = LOG_VCOUNT'(V_ACTIVE);

    logic [1:0]       state;
    logic             blank;
    logic             swap_pending;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       age;   // cycles since the accepted flag, saturating

    logic accept, req_vblank, req_blank, do_swap, buf_nxt;

    assign accept     = vga_flag && (state == S_IDLE || state == S_DONE);
    assign req_vblank = clocked_vcount >= V_LIM;
    assign req_blank  = req_vblank || (clocked_hcount >= H_LIM);
    // A frame_flag arriving with the blank request still counts for that request.
    assign do_swap    = accept && req_vblank && (swap_pending || frame_flag);
    assign buf_nxt    = rd_buf ^ do_swap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            blank        <= 1'b0;
            swap_pending <= 1'b0;
            cnt          <= '0;
            age          <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            vga_pixel    <= '0;
            done_vga     <= 1'b0;
            rd_buf       <= 1'b0;
            overrun      <= 1'b0;
            late         <= 1'b0;
        end else begin
            done_vga <= 1'b0;
            if (age != 4'hF) age <= age + 4'd1;

            if (do_swap) begin
                rd_buf       <= ~rd_buf;
                swap_pending <= 1'b0;
            end else if (frame_flag) begin
                swap_pending <= 1'b1;
            end

            if (vga_flag && (state == S_REQ || state == S_WAIT)) overrun <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (accept) begin
                        mem.mem_addr <= mk_addr(buf_nxt, clocked_vcount[8:0], clocked_hcount[9:1]);
                        blank        <= req_blank;
                        mem.mem_req  <= ~req_blank;
                        age          <= 4'd1;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Blank requests never touch memory and proceed as if granted.
                    if (blank || mem.mem_grant) begin
                        mem.mem_req <= 1'b0;
                        cnt         <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        vga_pixel <= blank ? '0 : mem.mem_rdata;
                        done_vga  <= 1'b1;
                        if (age > 4'd3) late <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch: reset values, directed table, random
// 4-cycle-spaced stream against a transaction-level model, reset mid-fetch.
module tb_vga_fetch;
    import vga_fetch_pkg::*;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_flag, frame_flag;
    logic [9:0]  hc, vc;
    logic [35:0] vga_pixel;
    logic        done_vga, rd_buf, overrun, late;

    always #5 clock = ~clock;

    vga_fetch_if mif();

    vga_fetch #(.MEM_LATENCY(LAT), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clock(clock), .reset(reset), .vga_flag(vga_flag),
        .clocked_hcount(hc), .clocked_vcount(vc), .frame_flag(frame_flag),
        .mem(mif), .vga_pixel(vga_pixel), .done_vga(done_vga),
        .rd_buf(rd_buf), .overrun(overrun), .late(late));

    int checks = 0, errors = 0;
    bit m_buf, m_pend, m_late, m_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] rand36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [18:0] ref_addr(input bit b, input int v, input int h);
        return 19'(b * 262144 + (v % 512) * 512 + h / 2);
    endfunction

    task automatic pulse_frame();
        frame_flag = 1'b1;
        @(negedge clock);
        frame_flag = 1'b0;
        m_pend = 1'b1;
    endtask

    // Entered and left at a negedge; the flag goes out in the entry cycle and
    // the task returns in the done cycle, so back-to-back calls are 4 apart.
    task automatic do_fetch(input int h, input int v, input int delay, input logic [35:0] data,
                            input bit frm, input int ov_cyc, input string tag,
                            output logic [18:0] addr_seen);
        bit blank;
        int exp_done, reqs, g, done_at;
        bit req_seen;
        blank = (h >= 640) || (v >= 480);
        if (v >= 480 && (m_pend || frm)) begin m_buf = ~m_buf; m_pend = 1'b0; end
        else if (frm) m_pend = 1'b1;
        exp_done = blank ? 4 : 4 + delay;
        reqs = 0; g = -1; done_at = -1; req_seen = 0; addr_seen = '0;
        vga_flag = 1'b1; hc = 10'(h); vc = 10'(v); frame_flag = frm;
        mif.mem_grant = 1'b0; mif.mem_rdata = rand36();
        for (int c = 1; c <= 30 && done_at < 0; c++) begin
            @(negedge clock);
            vga_flag = 1'b0; frame_flag = 1'b0; mif.mem_grant = 1'b0; mif.mem_rdata = rand36();
            if (done_vga) done_at = c;
            else begin
                if (mif.mem_req) begin
                    if (!req_seen) begin
                        req_seen = 1; addr_seen = mif.mem_addr;
                        chk({tag, " req_cycle"}, 64'(c), 64'd1);
                        chk({tag, " mem_addr"}, 64'(mif.mem_addr), 64'(ref_addr(m_buf, v, h)));
                    end
                    if (reqs >= delay && g < 0) begin mif.mem_grant = 1'b1; g = c; end
                    reqs++;
                end
                if (g >= 0 && c == g + LAT) mif.mem_rdata = data;
                if (c == ov_cyc) begin
                    vga_flag = 1'b1; hc = 10'($urandom_range(0, 639)); vc = 10'($urandom_range(0, 479));
                end
            end
        end
        if (exp_done > 4) m_late = 1'b1;
        if (ov_cyc > 0) m_ov = 1'b1;
        chk({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
        chk({tag, " vga_pixel"}, 64'(vga_pixel), 64'(blank ? 36'd0 : data));
        chk({tag, " mem_req_seen"}, 64'(req_seen), 64'(!blank));
        chk({tag, " rd_buf"}, 64'(rd_buf), 64'(m_buf));
        chk({tag, " late"}, 64'(late), 64'(m_late));
        chk({tag, " overrun"}, 64'(overrun), 64'(m_ov));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_req"}, 64'(mif.mem_req), 64'd0);
        chk({tag, " mem_addr"}, 64'(mif.mem_addr), 64'd0);
        chk({tag, " vga_pixel"}, 64'(vga_pixel), 64'd0);
        chk({tag, " done_vga"}, 64'(done_vga), 64'd0);
        chk({tag, " rd_buf"}, 64'(rd_buf), 64'd0);
        chk({tag, " overrun"}, 64'(overrun), 64'd0);
        chk({tag, " late"}, 64'(late), 64'd0);
    endtask

    typedef struct {
        int          h, v, delay, ov_cyc;
        logic [35:0] data;
        bit          pre_frame, frm, exp_req;
        logic [18:0] exp_addr;
        bit          exp_buf, exp_late, exp_ov;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [18:0] a;
        tbl[0] = '{100, 10, 0, 0, 36'h123456789, 0, 0, 1, 19'h01432, 0, 0, 0};
        tbl[1] = '{700, 10, 0, 0, 36'hABCDEF012, 0, 0, 0, 19'h00000, 0, 0, 0};
        tbl[2] = '{0,  490, 0, 0, 36'h555555555, 1, 0, 0, 19'h00000, 1, 0, 0};
        tbl[3] = '{0,    0, 0, 0, 36'hFEDCBA987, 0, 0, 1, 19'h40000, 1, 0, 0};
        tbl[4] = '{20,   5, 3, 5, 36'h111222333, 0, 0, 1, 19'h40A0A, 1, 1, 1};
        tbl[5] = '{300, 200, 0, 0, 36'h0CAFEF00D, 0, 0, 1, 19'h59096, 1, 1, 1};
        tbl[6] = '{0,  500, 0, 0, 36'h777777777, 0, 1, 0, 19'h00000, 0, 1, 1};
        tbl[7] = '{2,    1, 0, 0, 36'h9ABCDEF01, 0, 0, 1, 19'h00201, 0, 1, 1};

        reset = 1'b1; vga_flag = 0; frame_flag = 0; hc = 0; vc = 0;
        mif.mem_grant = 0; mif.mem_rdata = 0;
        m_buf = 0; m_pend = 0; m_late = 0; m_ov = 0;
        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Random stream at minimum spacing with immediate grants.
        for (int i = 0; i < 200; i++)
            do_fetch($urandom_range(0, 799), $urandom_range(0, 524), 0, rand36(),
                     $urandom_range(0, 9) == 0, 0, "rnd", a);
        chk("stream overrun", 64'(overrun), 64'd0);
        chk("stream late", 64'(late), 64'd0);

        reset = 1'b1; @(negedge clock); reset = 1'b0;
        m_buf = 0; m_pend = 0; m_late = 0; m_ov = 0;

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            if (tbl[i].pre_frame) pulse_frame();
            do_fetch(tbl[i].h, tbl[i].v, tbl[i].delay, tbl[i].data, tbl[i].frm,
                     tbl[i].ov_cyc, t, a);
            if (tbl[i].exp_req) chk({t, " tbl_addr"}, 64'(a), 64'(tbl[i].exp_addr));
            chk({t, " tbl_buf"}, 64'(rd_buf), 64'(tbl[i].exp_buf));
            chk({t, " tbl_late"}, 64'(late), 64'(tbl[i].exp_late));
            chk({t, " tbl_ovr"}, 64'(overrun), 64'(tbl[i].exp_ov));
        end

        // Pixel must hold with no further strobes while idle.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("hold done_vga", 64'(done_vga), 64'd0);
            chk("hold vga_pixel", 64'(vga_pixel), 64'(36'h9ABCDEF01));
        end

        // Reset while waiting for memory data.
        vga_flag = 1'b1; hc = 10'd64; vc = 10'd64;
        @(negedge clock); vga_flag = 1'b0;
        chk("rst_seq mem_req", 64'(mif.mem_req), 64'd1);
        mif.mem_grant = 1'b1;
        @(negedge clock); mif.mem_grant = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clock);
        mif.mem_rdata = 36'hDEADBEEF1;
        reset = 1'b0;
        m_buf = 0; m_pend = 0; m_late = 0; m_ov = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("post_reset quiet", 64'(done_vga | mif.mem_req), 64'd0);
        end
        do_fetch(128, 33, 0, 36'h2468ACE13, 0, 0, "after_reset", a);
        chk("after_reset addr", 64'(a), 64'(19'h04240));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
